// File: rtl/cal_serial_ctrl.sv
// Bit-serial sequencer: one cal cell stepped N times LSB-first with a recirculated carry,
// producing an N-bit result plus carry, zero and signed-overflow flags.
module cal_serial_ctrl #(
    parameter  int N  = 8,
    localparam int CW = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         l,
    input  logic [1:0]   s,
    input  logic         sub,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         c_out,
    output logic         zero,
    output logic         ovf
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(N - 2);

    // One cal cell: returns {carry_out, out}. Logic path: 0=AND, 1=OR, 2=XOR, 3=NOR.
    function automatic logic [1:0] cal_cell(input logic ai, input logic bi, input logic ci,
                                            input logic li, input logic [1:0] si);
        logic lo;
        logic co;
        logic so;
        so = ai ^ bi ^ ci;
        co = (ai & bi) | (ci & (ai ^ bi));
        case (si)
            2'd0:    lo = ai & bi;
            2'd1:    lo = ai | bi;
            2'd2:    lo = ai ^ bi;
            default: lo = ~(ai | bi);
        endcase
        return li ? {1'b0, lo} : {co, so};
    endfunction

    state_t        state_q;
    logic [N-1:0]  a_sh_q, b_sh_q, res_sh_q;
    logic          l_q, sub_q;
    logic [1:0]    s_q;
    logic          carry_q, c_msb_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q, done_q, c_out_q, zero_q, ovf_q;
    logic [N-1:0]  result_q;

    logic          cell_b;
    logic [1:0]    cell_q;
    logic          cell_out, cell_co;
    logic [N-1:0]  res_sh_d;

    always_comb begin
        cell_b   = b_sh_q[0] ^ (sub_q & ~l_q);
        cell_q   = cal_cell(a_sh_q[0], cell_b, carry_q, l_q, s_q);
        cell_co  = cell_q[1];
        cell_out = cell_q[0];
        res_sh_d = {cell_out, res_sh_q[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            l_q      <= 1'b0;
            s_q      <= 2'd0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            c_msb_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        l_q     <= l;
                        s_q     <= s;
                        sub_q   <= sub;
                        cnt_q   <= '0;
                        carry_q <= sub & ~l;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_sh_q <= res_sh_d;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= cell_co;
                    cnt_q    <= cnt_q + CW'(1);
                    // Cell carry-out of bit N-2 is the carry into the MSB.
                    if (cnt_q == CNT_PENULT)
                        c_msb_q <= cell_co;
                    if (cnt_q == CNT_LAST) begin
                        result_q <= res_sh_d;
                        c_out_q  <= cell_co & ~l_q;
                        zero_q   <= (res_sh_d == '0);
                        ovf_q    <= (c_msb_q ^ cell_co) & ~l_q;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_out_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_cal_serial_ctrl.sv
// Scoreboard bench for cal_serial_ctrl (N=8): directed operations push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_cal_serial_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset, start, l, sub;
    logic [N-1:0] a, b;
    logic [1:0]   s;
    logic         busy, done, c_out, zero, ovf;
    logic [N-1:0] result;

    cal_serial_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .l(l), .s(s), .sub(sub),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", int'(result), int'(e.r));
                chk("c_out", int'(c_out), int'(e.c));
                chk("zero", int'(zero), int'(e.z));
                chk("ovf", int'(ovf), int'(e.v));
            end
        end
    end

    function automatic logic [N-1:0] cl_model(input logic [N-1:0] x, input logic [N-1:0] y,
                                              input logic [1:0] fs);
        case (fs)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    // Called at a negedge with DUT in IDLE; returns at the negedge after DONE->IDLE.
    task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tl,
                         input logic [1:0] ts, input logic tsub, input logic [N-1:0] er,
                         input logic ec, input logic ez, input logic ev, input bit glitch);
        int busy_n;
        int done_at;
        exp_t e;
        a = ta; b = tb; l = tl; s = ts; sub = tsub; start = 1'b1;
        e.r = er; e.c = ec; e.z = ez; e.v = ev;
        sb.push_back(e);
        @(posedge clk);
        busy_n  = 0;
        done_at = -1;
        for (int k = 0; k <= N + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                a = ~ta; b = ~tb; l = ~tl; s = ~ts; sub = ~tsub;
            end
            if (glitch && k == 3) begin
                start = 1'b1; a = 8'h11; b = 8'h22;
            end
            if (glitch && k == 4) start = 1'b0;
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = k;
        end
        chk("busy_cycles", busy_n, N + 1);
        chk("done_latency", done_at, N);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int gap;
        exp_t e;
        reset = 1'b1; start = 1'b0; a = '0; b = '0; l = 1'b0; s = 2'd0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'({c_out, zero, ovf}), 0);
        // start together with reset must be ignored
        start = 1'b1; a = 8'h12; b = 8'h34;
        @(negedge clk);
        chk("rst_start_busy", int'(busy), 0);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);

        do_op(8'h3C, 8'h0F, 1'b0, 2'd0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 2'd0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op(8'h05, 8'h07, 1'b0, 2'd0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int fs = 0; fs < 4; fs++)
            do_op(8'hA5, 8'h3C, 1'b1, 2'(fs), fs[0], cl_model(8'hA5, 8'h3C, 2'(fs)),
                  1'b0, 1'b0, 1'b0, 1'b0);
        do_op(8'h80, 8'h01, 1'b0, 2'd0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset at cnt==4: no done, all outputs cleared (previous result 0x7F, c=1, ovf=1)
        a = 8'h80; b = 8'h01; l = 1'b0; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_c_out", int'(c_out), 0);
        chk("midrst_ovf", int'(ovf), 0);
        chk("midrst_zero", int'(zero), 0);
        repeat (N + 2) @(negedge clk);
        do_op(8'h01, 8'h01, 1'b0, 2'd0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start pulse mid-run is ignored
        do_op(8'h3C, 8'h0F, 1'b0, 2'd0, 1'b0, 8'h4B, 1'b0, 1'b0, 1'b0, 1'b1);

        // Start held high: two operations, done pulses N+2 cycles apart
        a = 8'h10; b = 8'h20; l = 1'b0; s = 2'd0; sub = 1'b0; start = 1'b1;
        e.r = 8'h30; e.c = 1'b0; e.z = 1'b0; e.v = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        a = 8'h40; b = 8'h40;
        e.r = 8'h80; e.c = 1'b0; e.z = 1'b0; e.v = 1'b1;
        sb.push_back(e);
        cyc = 0;
        while (!done && cyc < 4 * N) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b_first_done", int'(done), 1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!done && gap < 4 * N);
        chk("b2b_gap", gap, N + 2);
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
